// File: rtl/pipe_pkg.sv
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for the pipeline boundary register |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam int MAX_STAGES = 4;

  // Decode/execute control bundle; zero-extended to CTRL_W at the boundary.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic [1:0] branch;
    logic [2:0] alu_control;
    logic       alu_src;
    logic [1:0] imm_src;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_BUBBLE = '0;

  function automatic logic stages_ok(input int n);
    return (n >= 1) && (n <= MAX_STAGES);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_slot.sv
// +--------------------------------------------------------------------------+
// | pipe_stage_slot : one valid/ctrl/data slot with handshake and flush      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              in_ready;

  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      // Data is deliberately left alone so flushes cost no datapath toggles.
      valid_d = 1'b0;
      ctrl_d  = CTRL_W'(CTRL_BUBBLE);
    end else if (in_ready) begin
      if (in_valid) begin
        valid_d = 1'b1;
        ctrl_d  = in_ctrl;
        data_d  = in_data;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_W'(CTRL_BUBBLE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +--------------------------------------------------------------------------+
// | pipe_stage_reg : STAGES-deep pipeline boundary register with flush.      |
// | Optional one-entry input skid buffer selected by macro PIPE_SKID_EN.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  output logic              ready_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  input  logic              flush,
  output logic              valid_e,
  input  logic              ready_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [DATA_W-1:0] data_e
);

  if (!stages_ok(STAGES)) begin : g_stages_check
    $error("pipe_stage_reg: STAGES must be within 1..MAX_STAGES");
  end

  logic [STAGES-1:0] slot_valid;
  logic [STAGES-1:0] slot_out_ready;
  logic [CTRL_W-1:0] slot_ctrl [STAGES];
  logic [DATA_W-1:0] slot_data [STAGES];

  logic              head_valid;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic              head_in_ready;
  logic              chain_rdy;

  // Readiness is derived from the valid flops walking back from the output,
  // so no combinational path runs through a slot's own ready signal.
  always_comb begin
    slot_out_ready = '0;
    chain_rdy      = ready_e;
    for (int k = STAGES - 1; k >= 0; k--) begin
      slot_out_ready[k] = chain_rdy;
      chain_rdy         = chain_rdy | ~slot_valid[k];
    end
    head_in_ready = chain_rdy;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    if (k == 0) begin : g_head
      assign in_valid = head_valid;
      assign in_ctrl  = head_ctrl;
      assign in_data  = head_data;
    end else begin : g_body
      assign in_valid = slot_valid[k-1];
      assign in_ctrl  = slot_ctrl[k-1];
      assign in_data  = slot_data[k-1];
    end

    pipe_stage_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_ready (slot_out_ready[k]),
      .out_valid (slot_valid[k]),
      .out_ctrl  (slot_ctrl[k]),
      .out_data  (slot_data[k])
    );
  end

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      skid_valid_d = 1'b0;
      skid_ctrl_d  = CTRL_W'(CTRL_BUBBLE);
    end else if (skid_valid_q) begin
      if (head_in_ready) begin
        skid_valid_d = 1'b0;
        skid_ctrl_d  = CTRL_W'(CTRL_BUBBLE);
      end
    end else if (valid_d && !head_in_ready) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = ctrl_d;
      skid_data_d  = data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // A parked item always drains ahead of fresh input; ready_d is low then.
  assign head_valid = skid_valid_q ? 1'b1        : valid_d;
  assign head_ctrl  = skid_valid_q ? skid_ctrl_q : ctrl_d;
  assign head_data  = skid_valid_q ? skid_data_q : data_d;
  assign ready_d    = ~skid_valid_q;
`else
  assign head_valid = valid_d;
  assign head_ctrl  = ctrl_d;
  assign head_data  = data_d;
  assign ready_d    = head_in_ready;
`endif

  assign valid_e = slot_valid[STAGES-1];
  assign ctrl_e  = slot_ctrl[STAGES-1];
  assign data_e  = slot_data[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_reg : scoreboard bench for pipe_stage_reg (STAGES=2)       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 128;
  localparam int S  = 2;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_d = 1'b0;
  logic          ready_d;
  logic [CW-1:0] ctrl_d = '0;
  logic [DW-1:0] data_d = '0;
  logic          flush = 1'b0;
  logic          valid_e;
  logic          ready_e = 1'b0;
  logic [CW-1:0] ctrl_e;
  logic [DW-1:0] data_e;

  int    n_cmp = 0;
  int    n_err = 0;
  item_t sb_q[$];
  item_t sb_it;
  logic  hs;

  pipe_stage_reg #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .STAGES (S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_d (valid_d),
    .ready_d (ready_d),
    .ctrl_d  (ctrl_d),
    .data_d  (data_d),
    .flush   (flush),
    .valid_e (valid_e),
    .ready_e (ready_e),
    .ctrl_e  (ctrl_e),
    .data_e  (data_e)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h required %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: accepted inputs are queued, delivered outputs must match in order.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (!valid_e) check_eq("bubble_ctrl", DW'(ctrl_e), '0);
      if (valid_e && ready_e) begin
        check_eq("sb_nonempty", DW'(sb_q.size() != 0), DW'(1'b1));
        if (sb_q.size() != 0) begin
          sb_it = sb_q.pop_front();
          check_eq("out_ctrl", DW'(ctrl_e), DW'(sb_it.c));
          check_eq("out_data", data_e, sb_it.d);
        end
      end
      if (flush) sb_q.delete();
      else if (valid_d && ready_d) sb_q.push_back('{c: ctrl_d, d: data_d});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid_e", DW'(valid_e), '0);
    check_eq("rst_ctrl_e",  DW'(ctrl_e),  '0);
    check_eq("rst_data_e",  data_e,       '0);
    check_eq("rst_ready_d", DW'(ready_d), DW'(1'b1));

    // Streaming: three back-to-back items, latency S
    cyc();
    ready_e = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_d = (i < 3);
      ctrl_d  = CW'(16'h0011 * (i + 1));
      data_d  = rnd_data();
      @(negedge clk);
      check_eq("stream_valid_e", DW'(valid_e), DW'(i >= S && i < S + 3));
      if (i >= S && i < S + 3) check_eq("stream_ctrl_e", DW'(ctrl_e), DW'(CW'(16'h0011 * (i - S + 1))));
      cyc();
    end
    valid_d = 1'b0;

    // Stall: output held, upstream blocked once both slots are full
    ready_e = 1'b0;
    valid_d = 1'b1; ctrl_d = 16'hAAAA; data_d = rnd_data();
    @(negedge clk);
    check_eq("stall_rdy_a", DW'(ready_d), DW'(1'b1));
    cyc();
    ctrl_d = 16'hBBBB; data_d = rnd_data();
    @(negedge clk);
    check_eq("stall_rdy_b", DW'(ready_d), DW'(1'b1));
    cyc();
    ctrl_d = 16'hCCCC; data_d = rnd_data();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid_e", DW'(valid_e), DW'(1'b1));
      check_eq("stall_ctrl_e",  DW'(ctrl_e),  DW'(16'hAAAA));
      check_eq("stall_ready_d", DW'(ready_d), '0);
      cyc();
    end
    ready_e = 1'b1;
    @(negedge clk);
    check_eq("unstall_ctrl_a", DW'(ctrl_e),  DW'(16'hAAAA));
    check_eq("unstall_rdy",    DW'(ready_d), DW'(1'b1));
    cyc();
    valid_d = 1'b0;
    @(negedge clk);
    check_eq("unstall_ctrl_b", DW'(ctrl_e), DW'(16'hBBBB));
    cyc();
    @(negedge clk);
    check_eq("unstall_ctrl_c", DW'(ctrl_e), DW'(16'hCCCC));
    cyc();

    // Flush with a full pipe, output handshake and upstream offer in the same cycle
    ready_e = 1'b0;
    valid_d = 1'b1; ctrl_d = 16'h0101; data_d = rnd_data();
    cyc();
    ctrl_d = 16'h0202; data_d = rnd_data();
    cyc();
    ctrl_d = 16'h0303; data_d = rnd_data();
    ready_e = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_out_valid", DW'(valid_e), DW'(1'b1));
    check_eq("flush_out_ctrl",  DW'(ctrl_e),  DW'(16'h0101));
    check_eq("flush_rdy",       DW'(ready_d), DW'(1'b1));
    cyc();
    flush = 1'b0;
    valid_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_flush_valid", DW'(valid_e), '0);
      check_eq("post_flush_ctrl",  DW'(ctrl_e),  '0);
      check_eq("post_flush_rdy",   DW'(ready_d), DW'(1'b1));
      cyc();
    end

    // Asynchronous reset while stalled and holding two items
    ready_e = 1'b0;
    valid_d = 1'b1; ctrl_d = 16'h0606; data_d = rnd_data();
    cyc();
    ctrl_d = 16'h0707; data_d = rnd_data();
    cyc();
    valid_d = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_valid", DW'(valid_e), DW'(1'b1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_valid_e", DW'(valid_e), '0);
    check_eq("arst_ctrl_e",  DW'(ctrl_e),  '0);
    check_eq("arst_data_e",  data_e,       '0);
    check_eq("arst_ready_d", DW'(ready_d), DW'(1'b1));
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", DW'(valid_e), '0);

    // Random traffic with back-pressure and occasional flush
    hs = 1'b0;
    cyc();
    for (int n = 0; n < 400; n++) begin
      if (!valid_d || hs) begin
        valid_d = ($urandom_range(0, 3) != 0);
        ctrl_d  = CW'($urandom());
        data_d  = rnd_data();
      end
      ready_e = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      hs = valid_d & ready_d;
      cyc();
    end

    // Drain
    valid_d = 1'b0;
    flush   = 1'b0;
    ready_e = 1'b1;
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) cyc();
    check_eq("drain_empty", DW'(sb_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
